uart_tx_arbiter: RTL and testbench

//   Packet-atomic round-robin arbiter that shares one UART TX FIFO between NUM_CLIENTS byte-stream clients.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX FIFO push port
// between NUM_CLIENTS byte-stream clients. An owner keeps the port until
// it sends its last byte, reaches MAX_BURST bytes, or idles TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [NUM_CLIENTS-1:0]           i_valid,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] i_data,
  input  logic [NUM_CLIENTS-1:0]           i_last,
  output logic [NUM_CLIENTS-1:0]           o_ready,
  output logic                             o_fifo_wr_en,
  output logic [DATA_BITS-1:0]             o_fifo_data,
  input  logic                             i_fifo_full,
  output logic [NUM_CLIENTS-1:0]           o_grant,
  output logic                             o_busy
);

  localparam int unsigned PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 r_state,     w_state_nxt;
  logic [NUM_CLIENTS-1:0] r_grant,     w_grant_nxt;
  logic [PW-1:0]          r_owner,     w_owner_nxt;
  logic [PW-1:0]          r_rr_ptr,    w_rr_nxt;
  logic [BW-1:0]          r_burst_cnt, w_burst_nxt;
  logic [TW-1:0]          r_idle_cnt,  w_idle_nxt;

  logic                   w_own_valid;
  logic                   w_own_last;
  logic [DATA_BITS-1:0]   w_own_data;
  logic [SW-1:0]          w_scan;
  logic                   w_pick_found;
  logic [PW-1:0]          w_pick_idx;
  logic [NUM_CLIENTS-1:0] w_pick_oh;
  logic [PW-1:0]          w_owner_inc;
  logic                   w_beat;
  logic                   w_release;

  assign o_grant = r_grant;
  assign o_busy  = (r_state == ST_LOCKED);

  // Select the current owner's valid/last/data lane using the one-hot grant.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      if (r_grant[c]) begin
        w_own_valid = i_valid[c];
        w_own_last  = i_last[c];
        w_own_data  = i_data[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    w_scan       = '0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      w_scan = {1'b0, r_rr_ptr} + SW'(k);
      if (w_scan >= SW'(NUM_CLIENTS)) begin
        w_scan = w_scan - SW'(NUM_CLIENTS);
      end
      if (!w_pick_found && i_valid[w_scan[PW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_scan[PW-1:0];
      end
    end
  end

  assign w_pick_oh   = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_owner_inc = (r_owner == PW'(NUM_CLIENTS - 1)) ? '0 : r_owner + PW'(1);

  // Next-state, counters and the combinational FIFO push path.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_nxt     = r_rr_ptr;
    w_burst_nxt  = r_burst_cnt;
    w_idle_nxt   = r_idle_cnt;
    w_beat       = 1'b0;
    w_release    = 1'b0;
    o_ready      = '0;
    o_fifo_wr_en = 1'b0;
    o_fifo_data  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = w_pick_oh;
          w_owner_nxt = w_pick_idx;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end

      ST_LOCKED: begin
        o_ready      = r_grant & {NUM_CLIENTS{~i_fifo_full}};
        w_beat       = w_own_valid & ~i_fifo_full;
        o_fifo_wr_en = w_beat;
        if (w_beat) begin
          o_fifo_data = w_own_data;
          w_burst_nxt = r_burst_cnt + BW'(1);
          w_idle_nxt  = '0;
          if (w_own_last) begin
            w_release = 1'b1;
          end
          if ((MAX_BURST != 0) && (w_burst_nxt == BW'(MAX_BURST))) begin
            w_release = 1'b1;
          end
        end else if (!w_own_valid) begin
          // Stalled-by-full with valid high holds the idle count.
          w_idle_nxt = r_idle_cnt + TW'(1);
          if ((TIMEOUT != 0) && (w_idle_nxt == TW'(TIMEOUT))) begin
            w_release = 1'b1;
          end
        end

        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_owner_inc;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_idle_cnt  <= w_idle_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 clients, MAX_BURST=4, TIMEOUT=8).
module tb_uart_tx_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned DB = 8;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [NC-1:0]    i_valid;
  logic [NC*DB-1:0] i_data;
  logic [NC-1:0]    i_last;
  logic [NC-1:0]    o_ready;
  logic             o_fifo_wr_en;
  logic [DB-1:0]    o_fifo_data;
  logic             i_fifo_full;
  logic [NC-1:0]    o_grant;
  logic             o_busy;

  int n_checks = 0;
  int n_errs   = 0;

  int idx [NC];

  logic [3:0] exp_g4 [8]  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
  logic       exp_w4 [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] exp_g5 [13] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
                              4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h0};
  logic [3:0] exp_order [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_CLIENTS(NC),
    .DATA_BITS  (DB),
    .MAX_BURST  (4),
    .TIMEOUT    (8)
  ) u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_fifo_wr_en(o_fifo_wr_en),
    .o_fifo_data (o_fifo_data),
    .i_fifo_full (i_fifo_full),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_lane(input int c, input logic v, input logic [7:0] d, input logic l);
    i_valid[c]         = v;
    i_data[c*DB +: DB] = d;
    i_last[c]          = l;
  endtask

  task automatic apply_reset();
    i_valid     = '0;
    i_data      = '0;
    i_last      = '0;
    i_fifo_full = 1'b0;
    n_rst       = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] acc;
    logic [3:0] prev_g;
    int         ngr;
    int         cur;
    int         last_gcyc;
    int         k;
    logic       sent0;
    logic       sent3;

    // Reset state
    n_rst       = 1'b0;
    i_valid     = '0;
    i_data      = '0;
    i_last      = '0;
    i_fifo_full = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_wr",    32'(o_fifo_wr_en), 32'h0);
    check("rst_data",  32'(o_fifo_data), 32'h0);
    n_rst = 1'b1;
    tick();

    // T1: client 1 sends 0x41,0x42,0x43
    drive_lane(1, 1'b1, 8'h41, 1'b0);
    settle();
    check("t1_idle_grant", 32'(o_grant), 32'h0);
    check("t1_idle_ready", 32'(o_ready), 32'h0);
    check("t1_idle_wr",    32'(o_fifo_wr_en), 32'h0);
    tick();
    check("t1_grant", 32'(o_grant), 32'h2);
    check("t1_busy",  32'(o_busy), 32'h1);
    check("t1_ready", 32'(o_ready), 32'h2);
    check("t1_wr0",   32'(o_fifo_wr_en), 32'h1);
    check("t1_d0",    32'(o_fifo_data), 32'h41);
    tick();
    drive_lane(1, 1'b1, 8'h42, 1'b0);
    settle();
    check("t1_wr1", 32'(o_fifo_wr_en), 32'h1);
    check("t1_d1",  32'(o_fifo_data), 32'h42);
    tick();
    drive_lane(1, 1'b1, 8'h43, 1'b1);
    settle();
    check("t1_wr2", 32'(o_fifo_wr_en), 32'h1);
    check("t1_d2",  32'(o_fifo_data), 32'h43);
    tick();
    drive_lane(1, 1'b0, 8'h00, 1'b0);
    settle();
    check("t1_rel_grant", 32'(o_grant), 32'h0);
    check("t1_rel_busy",  32'(o_busy), 32'h0);
    check("t1_rel_wr",    32'(o_fifo_wr_en), 32'h0);

    // Pointer now 2: c0 and c2 both request, c2 must win first
    drive_lane(0, 1'b1, 8'hA0, 1'b1);
    drive_lane(2, 1'b1, 8'hC0, 1'b1);
    tick();
    check("t1_rr_grant", 32'(o_grant), 32'h4);
    check("t1_rr_d",     32'(o_fifo_data), 32'hC0);
    tick();
    drive_lane(2, 1'b0, 8'h00, 1'b0);
    settle();
    check("t1_rr_gap", 32'(o_grant), 32'h0);
    tick();
    check("t1_rr_next", 32'(o_grant), 32'h1);
    check("t1_rr_d0",   32'(o_fifo_data), 32'hA0);
    tick();
    drive_lane(0, 1'b0, 8'h00, 1'b0);

    // T2: all clients stream 2-byte packets
    apply_reset();
    for (int c = 0; c < NC; c++) idx[c] = 0;
    ngr       = 0;
    cur       = 0;
    last_gcyc = 0;
    prev_g    = '0;
    for (int cyc = 0; cyc < 20 && ngr < 5; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        drive_lane(c, 1'b1, 8'(c*16 + idx[c]), (idx[c] == 1));
      end
      settle();
      if (o_grant != 4'h0 && prev_g == 4'h0) begin
        check("t2_order", 32'(o_grant), 32'(exp_order[ngr]));
        if (ngr > 0) check("t2_gap", 32'(cyc - last_gcyc), 32'd3);
        for (int c = 0; c < NC; c++) if (exp_order[ngr][c]) cur = c;
        last_gcyc = cyc;
        ngr++;
      end
      if (o_fifo_wr_en) begin
        check("t2_data", 32'(o_fifo_data), 32'(8'(cur*16 + idx[cur])));
      end
      acc    = o_ready & i_valid;
      prev_g = o_grant;
      tick();
      for (int c = 0; c < NC; c++) begin
        if (acc[c]) idx[c] = (idx[c] == 1) ? 0 : idx[c] + 1;
      end
    end
    check("t2_ngrants", 32'(ngr), 32'd5);

    // T3: FIFO full for 10 cycles mid-packet
    apply_reset();
    drive_lane(0, 1'b1, 8'h10, 1'b0);
    tick();
    check("t3_grant", 32'(o_grant), 32'h1);
    check("t3_d0",    32'(o_fifo_data), 32'h10);
    tick();
    drive_lane(0, 1'b1, 8'h11, 1'b1);
    i_fifo_full = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      settle();
      check("t3_full_ready", 32'(o_ready), 32'h0);
      check("t3_full_wr",    32'(o_fifo_wr_en), 32'h0);
      check("t3_full_grant", 32'(o_grant), 32'h1);
      tick();
    end
    i_fifo_full = 1'b0;
    settle();
    check("t3_resume_ready", 32'(o_ready), 32'h1);
    check("t3_resume_wr",    32'(o_fifo_wr_en), 32'h1);
    check("t3_resume_d",     32'(o_fifo_data), 32'h11);
    tick();
    drive_lane(0, 1'b0, 8'h00, 1'b0);
    settle();
    check("t3_rel", 32'(o_grant), 32'h0);

    // T4: MAX_BURST=4, c2 streams 6 bytes without last
    apply_reset();
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive_lane(2, (k < 6), 8'(8'h20 + k), 1'b0);
      settle();
      check("t4_grant", 32'(o_grant), 32'(exp_g4[cyc]));
      check("t4_wr",    32'(o_fifo_wr_en), 32'(exp_w4[cyc]));
      if (exp_w4[cyc]) check("t4_data", 32'(o_fifo_data), 32'(8'(8'h20 + k)));
      if (o_ready[2] && i_valid[2]) k++;
      tick();
    end
    check("t4_count", 32'(k), 32'd6);

    // T5: TIMEOUT=8, c0 stops after 1 byte while c3 waits
    apply_reset();
    sent0 = 1'b0;
    sent3 = 1'b0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      drive_lane(0, !sent0, 8'h50, 1'b0);
      drive_lane(3, !sent3, 8'h3A, 1'b1);
      settle();
      check("t5_grant", 32'(o_grant), 32'(exp_g5[cyc]));
      check("t5_ready", 32'(o_ready), 32'(exp_g5[cyc]));
      check("t5_data",  32'(o_fifo_data),
            (cyc == 1) ? 32'h50 : ((cyc == 11) ? 32'h3A : 32'h0));
      if (o_ready[0] && i_valid[0]) sent0 = 1'b1;
      if (o_ready[3] && i_valid[3]) sent3 = 1'b1;
      tick();
    end
    drive_lane(0, 1'b0, 8'h00, 1'b0);
    drive_lane(3, 1'b0, 8'h00, 1'b0);

    // T6: reset while c3 owns the port with the pointer at 2
    drive_lane(1, 1'b1, 8'h61, 1'b1);
    tick();
    check("t6_c1_grant", 32'(o_grant), 32'h2);
    tick();
    drive_lane(1, 1'b0, 8'h00, 1'b0);
    drive_lane(3, 1'b1, 8'h71, 1'b0);
    tick();
    check("t6_c3_grant", 32'(o_grant), 32'h8);
    check("t6_c3_wr",    32'(o_fifo_wr_en), 32'h1);
    tick();
    drive_lane(3, 1'b1, 8'h72, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_rst_grant", 32'(o_grant), 32'h0);
    check("t6_rst_ready", 32'(o_ready), 32'h0);
    check("t6_rst_wr",    32'(o_fifo_wr_en), 32'h0);
    check("t6_rst_busy",  32'(o_busy), 32'h0);
    for (int c = 0; c < NC; c++) drive_lane(c, 1'b1, 8'(8'h80 + c), 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    check("t6_first_grant", 32'(o_grant), 32'h1);
    check("t6_first_data",  32'(o_fifo_data), 32'h80);
    i_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
